// File: rtl/regfile_wr_arbiter.sv
// Purpose: shares the integer regfile write port between writeback (priority) and a buffered long-latency unit.
// Latency: writeback passes through combinationally; a long-latency result reaches the port 1 cycle after push at the earliest.
// Backpressure: lu_ready drops when the buffer is full; stall_req asks the pipeline to idle one cycle when the head starves.
module regfile_wr_arbiter #(
  parameter int DEPTH    = 4,
  parameter int MAX_WAIT = 3,
  parameter int IDX_W    = 5,
  parameter int DATA_W   = 32
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         pipe_we,
  input  logic [IDX_W-1:0]             pipe_idx,
  input  logic [DATA_W-1:0]            pipe_data,
  input  logic                         lu_valid,
  output logic                         lu_ready,
  input  logic [IDX_W-1:0]             lu_idx,
  input  logic [DATA_W-1:0]            lu_data,
  output logic                         reg_we,
  output logic [IDX_W-1:0]             reg_idx,
  output logic [DATA_W-1:0]            reg_data,
  output logic                         stall_req,
  output logic [$clog2(DEPTH+1)-1:0]   pend_cnt,
  output logic                         protocol_err
);

  localparam int PTR_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W  = $clog2(DEPTH+1);
  localparam int WAIT_W = $clog2(MAX_WAIT+1);

  // Buffer storage. ent_vld marks occupied slots so a writeback kill only
  // touches entries that were already queued at the start of the cycle.
  logic [IDX_W-1:0]  ent_idx  [DEPTH];
  logic [DATA_W-1:0] ent_data [DEPTH];
  logic [DEPTH-1:0]  ent_vld;
  logic [DEPTH-1:0]  ent_live;

  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [CNT_W-1:0]  cnt;
  logic [WAIT_W-1:0] wait_cnt;
  logic [WAIT_W-1:0] wait_nxt;
  logic              stall_q;
  logic              perr_q;

  logic              empty;
  logic              push;
  logic              pop;
  logic              kill_en;
  logic [IDX_W-1:0]  head_idx;
  logic [DATA_W-1:0] head_data;
  logic              head_live;

  assign empty     = (cnt == '0);
  assign head_idx  = ent_idx[rd_ptr];
  assign head_data = ent_data[rd_ptr];
  assign head_live = ent_live[rd_ptr];

  // Acceptance uses only the registered count: a same-cycle pop does not
  // free a slot for the incoming result.
  assign lu_ready = !rst && (cnt < CNT_W'(DEPTH));
  assign push     = lu_valid && lu_ready;

  // Writeback owns the port whenever it asks; the head drains only in idle cycles.
  assign pop      = !rst && !pipe_we && !empty;

  // A younger writeback to the same register makes older buffered results stale.
  assign kill_en  = !rst && pipe_we && (pipe_idx != '0);

  assign stall_req    = stall_q;
  assign pend_cnt     = cnt;
  assign protocol_err = perr_q;

  // Write-port mux: writeback first, then buffer head; r0 and dead entries never write.
  always_comb begin
    reg_we   = 1'b0;
    reg_idx  = pipe_idx;
    reg_data = pipe_data;
    if (!rst) begin
      if (pipe_we) begin
        reg_we = (pipe_idx != '0);
      end else if (!empty) begin
        reg_we   = head_live && (head_idx != '0);
        reg_idx  = head_idx;
        reg_data = head_data;
      end
    end
  end

  // Starvation counter: counts blocked cycles of a waiting head, saturating at MAX_WAIT.
  always_comb begin
    wait_nxt = wait_cnt;
    if (empty || pop) begin
      wait_nxt = '0;
    end else if (wait_cnt < WAIT_W'(MAX_WAIT)) begin
      wait_nxt = wait_cnt + 1'b1;
    end
  end

  // Buffer update: kill stale entries, then pop head and append the new result.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      cnt      <= '0;
      ent_vld  <= '0;
      ent_live <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (kill_en && ent_vld[i] && (ent_idx[i] == pipe_idx)) begin
          ent_live[i] <= 1'b0;
        end
      end
      if (pop) begin
        ent_vld[rd_ptr] <= 1'b0;
        rd_ptr          <= rd_ptr + 1'b1;
      end
      // The push slot is never a valid entry, so it cannot collide with the
      // kill above; the new entry is younger than the writeback and stays live.
      if (push) begin
        ent_idx[wr_ptr]  <= lu_idx;
        ent_data[wr_ptr] <= lu_data;
        ent_vld[wr_ptr]  <= 1'b1;
        ent_live[wr_ptr] <= 1'b1;
        wr_ptr           <= wr_ptr + 1'b1;
      end
      case ({push, pop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

  // Status registers: wait counter, one-shot stall request, sticky protocol error.
  always_ff @(posedge clk) begin
    if (rst) begin
      wait_cnt <= '0;
      stall_q  <= 1'b0;
      perr_q   <= 1'b0;
    end else begin
      wait_cnt <= wait_nxt;
      stall_q  <= !pop && !empty && (wait_nxt == WAIT_W'(MAX_WAIT));
      perr_q   <= perr_q || (pipe_we && stall_q);
    end
  end

endmodule
